// File: rtl/top_uart_if.sv
// Local-bus slave port of the UART: decoded region select, address,
// write data/enable going in, gated read data coming back.
interface top_uart_if #(
   parameter int XLEN   = 32,
   parameter int AWIDTH = 12
);
   logic              sel;
   logic [AWIDTH-1:0] addr;
   logic [XLEN-1:0]   wdata;
   logic [2:0]        we;
   logic [XLEN-1:0]   rdata;

   modport master (output sel, output addr, output wdata, output we, input rdata);
   modport slave  (input sel, input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/top_uart.sv
// 8N1 UART on the local bus: TX/RX FIFOs, programmable baud divisor,
// sticky overrun/framing flags and a level rx_irq while RX data is waiting.
module top_uart #(
   parameter int XLEN       = 32,
   parameter int AWIDTH     = 12,
   parameter int FIFO_DEPTH = 8,
   parameter int DEF_DIV    = 434
)(
   input  logic       clk,
   input  logic       rst_n,
   top_uart_if.slave  bus,
   input  logic       uart_rx,
   output logic       uart_tx,
   output logic       rx_irq
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   // ---------------- bus decode ----------------
   logic       w_wr;
   logic [1:0] w_reg;
   logic       w_txd_wr, w_rxd_wr, w_stat_wr, w_baud_wr;

   assign w_wr      = bus.sel && (bus.we != 3'd0);
   assign w_reg     = bus.addr[3:2];
   assign w_txd_wr  = w_wr && (w_reg == 2'd0);
   assign w_rxd_wr  = w_wr && (w_reg == 2'd1);
   assign w_stat_wr = w_wr && (w_reg == 2'd2);
   assign w_baud_wr = w_wr && (w_reg == 2'd3);

   // ---------------- baud divisor ----------------
   logic [15:0] r_baud;

   // BAUDDIV register; values below 4 would leave no room for mid-bit sampling
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_baud <= 16'(DEF_DIV);
      end else if (w_baud_wr) begin
         r_baud <= (bus.wdata[15:0] < 16'd4) ? 16'd4 : bus.wdata[15:0];
      end
   end

   // ---------------- TX FIFO ----------------
   logic [7:0]    r_tx_mem [FIFO_DEPTH];
   logic [PW-1:0] r_tx_wptr, r_tx_rptr;
   logic [CW-1:0] r_tx_cnt;
   logic          w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
   logic [7:0]    w_tx_head;

   assign w_tx_empty = (r_tx_cnt == '0);
   assign w_tx_full  = (r_tx_cnt == CW'(FIFO_DEPTH));
   assign w_tx_head  = r_tx_mem[r_tx_rptr];
   // a full FIFO still accepts a push in the cycle the serializer drains it
   assign w_tx_push  = w_txd_wr && (!w_tx_full || w_tx_pop);

   // TX FIFO storage (data only, no reset needed)
   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wptr] <= bus.wdata[7:0];
   end

   // TX FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_wptr <= '0;
         r_tx_rptr <= '0;
         r_tx_cnt  <= '0;
      end else begin
         if (w_tx_push) r_tx_wptr <= r_tx_wptr + PW'(1);
         if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PW'(1);
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
            2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
            default: r_tx_cnt <= r_tx_cnt;
         endcase
      end
   end

   // ---------------- TX serializer ----------------
   state_t      r_tx_state;
   logic        r_tx;
   logic [15:0] r_tx_bcnt, r_tx_bdiv;
   logic [2:0]  r_tx_bit;
   logic [7:0]  r_tx_shift;
   logic        w_tx_tick, w_tx_busy;

   // r_tx_bdiv is latched at each bit start so a BAUDDIV write never stretches a bit in flight
   assign w_tx_tick = (r_tx_bcnt == r_tx_bdiv - 16'd1);
   assign w_tx_pop  = !w_tx_empty &&
                      ((r_tx_state == S_IDLE) || ((r_tx_state == S_STOP) && w_tx_tick));
   assign w_tx_busy = (r_tx_state != S_IDLE) || !w_tx_empty;
   assign uart_tx   = r_tx;

   // TX FSM: start, 8 data bits LSB first, stop; back-to-back frames when data is queued
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_state <= S_IDLE;
         r_tx       <= 1'b1;
         r_tx_bcnt  <= '0;
         r_tx_bdiv  <= 16'(DEF_DIV);
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
      end else begin
         case (r_tx_state)
            S_IDLE: begin
               r_tx <= 1'b1;
               if (w_tx_pop) begin
                  r_tx_state <= S_START;
                  r_tx       <= 1'b0;
                  r_tx_shift <= w_tx_head;
                  r_tx_bcnt  <= '0;
                  r_tx_bdiv  <= r_baud;
               end
            end
            S_START: begin
               if (w_tx_tick) begin
                  r_tx_state <= S_DATA;
                  r_tx       <= r_tx_shift[0];
                  r_tx_shift <= r_tx_shift >> 1;
                  r_tx_bit   <= '0;
                  r_tx_bcnt  <= '0;
                  r_tx_bdiv  <= r_baud;
               end else begin
                  r_tx_bcnt <= r_tx_bcnt + 16'd1;
               end
            end
            S_DATA: begin
               if (w_tx_tick) begin
                  r_tx_bcnt <= '0;
                  r_tx_bdiv <= r_baud;
                  if (r_tx_bit == 3'd7) begin
                     r_tx_state <= S_STOP;
                     r_tx       <= 1'b1;
                  end else begin
                     r_tx_bit   <= r_tx_bit + 3'd1;
                     r_tx       <= r_tx_shift[0];
                     r_tx_shift <= r_tx_shift >> 1;
                  end
               end else begin
                  r_tx_bcnt <= r_tx_bcnt + 16'd1;
               end
            end
            S_STOP: begin
               if (w_tx_tick) begin
                  r_tx_bcnt <= '0;
                  r_tx_bdiv <= r_baud;
                  if (w_tx_pop) begin
                     r_tx_state <= S_START;
                     r_tx       <= 1'b0;
                     r_tx_shift <= w_tx_head;
                  end else begin
                     r_tx_state <= S_IDLE;
                  end
               end else begin
                  r_tx_bcnt <= r_tx_bcnt + 16'd1;
               end
            end
            default: r_tx_state <= S_IDLE;
         endcase
      end
   end

   // ---------------- RX synchronizer ----------------
   logic r_rx_s1, r_rx_s2, r_rx_prev;
   logic w_rx_fall;

   // two-flop synchronizer plus one history flop for falling-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_s1   <= 1'b1;
         r_rx_s2   <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_s1   <= uart_rx;
         r_rx_s2   <= r_rx_s1;
         r_rx_prev <= r_rx_s2;
      end
   end

   assign w_rx_fall = r_rx_prev && !r_rx_s2;

   // ---------------- RX deserializer ----------------
   state_t      r_rx_state;
   logic [15:0] r_rx_bcnt, r_rx_bdiv;
   logic [2:0]  r_rx_bit;
   logic [7:0]  r_rx_shift;
   logic        w_rx_tick, w_rx_stop_smp;

   // start bit is checked half a bit after the edge; every later sample is a full bit apart
   assign w_rx_tick = (r_rx_state == S_START) ? (r_rx_bcnt == (r_rx_bdiv >> 1) - 16'd1)
                                              : (r_rx_bcnt == r_rx_bdiv - 16'd1);
   assign w_rx_stop_smp = (r_rx_state == S_STOP) && w_rx_tick;

   // RX FSM: edge -> start check (glitch reject) -> 8 data samples -> stop sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_state <= S_IDLE;
         r_rx_bcnt  <= '0;
         r_rx_bdiv  <= 16'(DEF_DIV);
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
      end else begin
         case (r_rx_state)
            S_IDLE: begin
               if (w_rx_fall) begin
                  r_rx_state <= S_START;
                  r_rx_bcnt  <= '0;
                  r_rx_bdiv  <= r_baud;
               end
            end
            S_START: begin
               if (w_rx_tick) begin
                  r_rx_bcnt  <= '0;
                  r_rx_bdiv  <= r_baud;
                  r_rx_bit   <= '0;
                  r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
               end else begin
                  r_rx_bcnt <= r_rx_bcnt + 16'd1;
               end
            end
            S_DATA: begin
               if (w_rx_tick) begin
                  r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                  r_rx_bcnt  <= '0;
                  r_rx_bdiv  <= r_baud;
                  if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
                  else                  r_rx_bit   <= r_rx_bit + 3'd1;
               end else begin
                  r_rx_bcnt <= r_rx_bcnt + 16'd1;
               end
            end
            S_STOP: begin
               if (w_rx_tick) begin
                  r_rx_state <= S_IDLE;
                  r_rx_bcnt  <= '0;
               end else begin
                  r_rx_bcnt <= r_rx_bcnt + 16'd1;
               end
            end
            default: r_rx_state <= S_IDLE;
         endcase
      end
   end

   // ---------------- RX FIFO ----------------
   logic [7:0]    r_rx_mem [FIFO_DEPTH];
   logic [PW-1:0] r_rx_wptr, r_rx_rptr;
   logic [CW-1:0] r_rx_cnt;
   logic          w_rx_empty, w_rx_full, w_rx_push, w_rx_pop;
   logic          w_ovr_set, w_fe_set;

   assign w_rx_empty = (r_rx_cnt == '0);
   assign w_rx_full  = (r_rx_cnt == CW'(FIFO_DEPTH));
   assign w_rx_pop   = w_rxd_wr && !w_rx_empty;
   // a bus pop in the same cycle frees the slot, so a full FIFO still takes the byte
   assign w_rx_push  = w_rx_stop_smp && r_rx_s2 && (!w_rx_full || w_rx_pop);
   assign w_ovr_set  = w_rx_stop_smp && r_rx_s2 && w_rx_full && !w_rx_pop;
   assign w_fe_set   = w_rx_stop_smp && !r_rx_s2;
   assign rx_irq     = !w_rx_empty;

   // RX FIFO storage (data only, no reset needed)
   always_ff @(posedge clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wptr] <= r_rx_shift;
   end

   // RX FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_wptr <= '0;
         r_rx_rptr <= '0;
         r_rx_cnt  <= '0;
      end else begin
         if (w_rx_push) r_rx_wptr <= r_rx_wptr + PW'(1);
         if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PW'(1);
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
            2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
            default: r_rx_cnt <= r_rx_cnt;
         endcase
      end
   end

   // ---------------- sticky error flags ----------------
   logic r_ovr, r_fe;

   // sticky flags: a new error in the clearing cycle wins over the clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovr <= 1'b0;
         r_fe  <= 1'b0;
      end else begin
         r_ovr <= w_ovr_set || (r_ovr && !(w_stat_wr && bus.wdata[4]));
         r_fe  <= w_fe_set  || (r_fe  && !(w_stat_wr && bus.wdata[5]));
      end
   end

   // ---------------- read mux ----------------
   logic [XLEN-1:0] w_rdata;

   // side-effect-free read data, forced to zero when the region is not selected
   always_comb begin
      w_rdata = '0;
      if (bus.sel) begin
         case (w_reg)
            2'd1: begin
               w_rdata[8]   = !w_rx_empty;
               w_rdata[7:0] = w_rx_empty ? 8'd0 : r_rx_mem[r_rx_rptr];
            end
            2'd2: w_rdata[6:0] = {w_tx_busy, r_fe, r_ovr, w_rx_full,
                                  w_rx_empty, w_tx_empty, w_tx_full};
            2'd3: w_rdata[15:0] = r_baud;
            default: w_rdata = '0;
         endcase
      end
   end

   assign bus.rdata = w_rdata;

endmodule

// File: tb/tb_top_uart.sv
// Self-checking bench for top_uart: register table, TX line waveforms,
// loopback, overrun/framing sequences and randomized RX frames vs a queue model.
module tb_top_uart;
   localparam int XLEN  = 32;
   localparam int AW    = 12;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic uart_rx, uart_tx, rx_irq;
   logic rx_drv = 1'b1;
   logic loop_en = 1'b0;
   logic mon_en = 1'b0;
   logic txq[$];
   logic expq[$];
   int   checks = 0;
   int   failures = 0;

   top_uart_if #(.XLEN(XLEN), .AWIDTH(AW)) u_bus ();

   assign uart_rx = loop_en ? uart_tx : rx_drv;

   top_uart #(.XLEN(XLEN), .AWIDTH(AW), .FIFO_DEPTH(DEPTH), .DEF_DIV(434)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (u_bus),
      .uart_rx (uart_rx),
      .uart_tx (uart_tx),
      .rx_irq  (rx_irq)
   );

   always #5 clk = ~clk;

   // line monitor: one sample per clock, taken after the edge has settled
   always @(posedge clk) begin
      #2;
      if (mon_en) txq.push_back(uart_tx);
   end

   typedef struct {
      logic        wr;
      logic        sel;
      logic [3:0]  a;
      logic [2:0]  we;
      logic [31:0] d;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vt[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d,
                            input logic s = 1'b1, input logic [2:0] we = 3'b001);
      @(negedge clk);
      u_bus.sel = s; u_bus.addr = {8'h00, a}; u_bus.wdata = d; u_bus.we = we;
      @(posedge clk);
      #1 u_bus.sel = 1'b0; u_bus.we = 3'd0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d, input logic s = 1'b1);
      @(negedge clk);
      u_bus.sel = s; u_bus.addr = {8'h00, a}; u_bus.we = 3'd0;
      #1 d = u_bus.rdata;
      u_bus.sel = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] v;
      bus_read(a, v);
      chk(name, v, exp);
   endtask

   // expected line levels for one 8N1 frame, one entry per clock
   task automatic add_frame(input logic [7:0] b, input int div);
      for (int k = 0; k < div; k++) expq.push_back(1'b0);
      for (int i = 0; i < 8; i++)
         for (int k = 0; k < div; k++) expq.push_back(b[i]);
      for (int k = 0; k < div; k++) expq.push_back(1'b1);
   endtask

   task automatic cmp_stream(input string name, input int n);
      int bad;
      bad = -1;
      for (int i = 0; i < n; i++)
         if (bad < 0 && (i >= txq.size() || txq[i] !== expq[i])) bad = i;
      checks++;
      if (bad >= 0) begin
         failures++;
         $display("FAIL %s: line differs at sample %0d got %0d expected %0d", name, bad,
                  (bad < txq.size()) ? int'(txq[bad]) : -1, int'(expq[bad]));
      end
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop, input int div);
      rx_drv = 1'b0;
      repeat (div) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         repeat (div) @(negedge clk);
      end
      rx_drv = stop;
      repeat (div) @(negedge clk);
      rx_drv = 1'b1;
      repeat (2 * div) @(negedge clk);
   endtask

   task automatic rx_glitch(input int div);
      rx_drv = 1'b0;
      repeat (div / 4) @(negedge clk);
      rx_drv = 1'b1;
      repeat (3 * div) @(negedge clk);
   endtask

   initial begin
      logic [7:0]  mq[$];
      logic        m_ovr, m_fe;
      logic [31:0] exp_st, exp_rd;
      int          div, kind;
      logic [7:0]  b;

      u_bus.sel = 1'b0; u_bus.addr = '0; u_bus.wdata = '0; u_bus.we = 3'd0;

      // ---- reset, then asynchronous reset in the middle of a frame ----
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      bus_write(4'hC, 32'd16);
      bus_write(4'h0, 32'h00);
      repeat (30) @(negedge clk);
      chk("tx_low_mid_frame", {31'd0, uart_tx}, 32'd0);
      #3 rst_n = 1'b0;
      #1 chk("tx_high_on_async_reset", {31'd0, uart_tx}, 32'd1);
      chk("irq_low_in_reset", {31'd0, rx_irq}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // ---- register table ----
      vt[0]  = '{1'b0, 1'b1, 4'h8, 3'd0, 32'h0,         32'h06,  "rst_status"};
      vt[1]  = '{1'b0, 1'b1, 4'hC, 3'd0, 32'h0,         32'd434, "rst_baud"};
      vt[2]  = '{1'b0, 1'b1, 4'h0, 3'd0, 32'h0,         32'h0,   "txdata_reads_zero"};
      vt[3]  = '{1'b0, 1'b1, 4'h4, 3'd0, 32'h0,         32'h0,   "rxdata_empty"};
      vt[4]  = '{1'b0, 1'b0, 4'hC, 3'd0, 32'h0,         32'h0,   "unselected_reads_zero"};
      vt[5]  = '{1'b1, 1'b1, 4'hC, 3'b100, 32'd2,       32'h0,   "wr_baud_2"};
      vt[6]  = '{1'b0, 1'b1, 4'hC, 3'd0, 32'h0,         32'd4,   "baud_clamp_2"};
      vt[7]  = '{1'b1, 1'b1, 4'hC, 3'b010, 32'hABCD1234, 32'h0,  "wr_baud_wide"};
      vt[8]  = '{1'b0, 1'b1, 4'hC, 3'd0, 32'h0,         32'h1234, "baud_low16"};
      vt[9]  = '{1'b1, 1'b1, 4'hC, 3'b111, 32'd3,       32'h0,   "wr_baud_3"};
      vt[10] = '{1'b0, 1'b1, 4'hC, 3'd0, 32'h0,         32'd4,   "baud_clamp_3"};
      vt[11] = '{1'b1, 1'b0, 4'hC, 3'b001, 32'd9,       32'h0,   "wr_unselected"};
      vt[12] = '{1'b0, 1'b1, 4'hC, 3'd0, 32'h0,         32'd4,   "baud_ignores_unselected"};
      vt[13] = '{1'b1, 1'b1, 4'h8, 3'b001, 32'hFFFFFFCF, 32'h0,  "wr_status_noclear"};
      vt[14] = '{1'b0, 1'b1, 4'h8, 3'd0, 32'h0,         32'h06,  "status_after_write"};
      for (int i = 0; i < 15; i++) begin
         if (vt[i].wr) bus_write(vt[i].a, vt[i].d, vt[i].sel, vt[i].we);
         else begin
            logic [31:0] v;
            bus_read(vt[i].a, v, vt[i].sel);
            chk(vt[i].name, v, vt[i].exp);
         end
      end

      // ---- TX single byte, BAUDDIV=8 ----
      bus_write(4'hC, 32'd8);
      @(negedge clk);
      txq.delete(); expq.delete(); mon_en = 1'b1;
      u_bus.sel = 1'b1; u_bus.addr = 12'h000; u_bus.wdata = 32'h55; u_bus.we = 3'b001;
      @(posedge clk);
      #1 u_bus.sel = 1'b0; u_bus.we = 3'd0;
      repeat (3) @(negedge clk);
      rd_chk("status_tx_busy", 4'h8, 32'h46);
      repeat (100) @(negedge clk);
      mon_en = 1'b0;
      expq.push_back(1'b1);
      add_frame(8'h55, 8);
      repeat (10) expq.push_back(1'b1);
      cmp_stream("tx_0x55_waveform", expq.size());
      rd_chk("status_tx_done", 4'h8, 32'h06);

      // ---- TX FIFO full while the line is busy, BAUDDIV=4 ----
      bus_write(4'hC, 32'd4);
      @(negedge clk);
      txq.delete(); expq.delete(); mon_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         u_bus.sel = 1'b1; u_bus.addr = 12'h000; u_bus.we = 3'b001;
         u_bus.wdata = (i == 0) ? 32'hFF : 32'(i);
      end
      @(posedge clk);
      #1 u_bus.sel = 1'b0; u_bus.we = 3'd0;
      rd_chk("status_tx_full", 4'h8, 32'h45);
      repeat (400) @(negedge clk);
      mon_en = 1'b0;
      expq.push_back(1'b1);
      add_frame(8'hFF, 4);
      for (int i = 1; i <= 8; i++) add_frame(8'(i), 4);
      repeat (20) expq.push_back(1'b1);
      cmp_stream("tx_full_stream", expq.size());

      // ---- RX loopback, BAUDDIV=16 ----
      bus_write(4'hC, 32'd16);
      loop_en = 1'b1;
      bus_write(4'h0, 32'hA3);
      repeat (200) @(negedge clk);
      chk("loop_irq_set", {31'd0, rx_irq}, 32'd1);
      rd_chk("loop_rxdata", 4'h4, 32'h1A3);
      bus_write(4'h4, 32'h0);
      chk("loop_irq_clear", {31'd0, rx_irq}, 32'd0);
      rd_chk("loop_rxdata_empty", 4'h4, 32'h000);
      loop_en = 1'b0;
      repeat (4) @(negedge clk);

      // ---- RX overrun and framing error ----
      for (int i = 0; i < 9; i++) rx_frame(8'h10 + 8'(i), 1'b1, 16);
      rd_chk("status_overrun", 4'h8, 32'h1A);
      rd_chk("head_after_overrun", 4'h4, 32'h110);
      rx_frame(8'h77, 1'b0, 16);
      rd_chk("status_frame_err", 4'h8, 32'h3A);
      rd_chk("head_after_frame_err", 4'h4, 32'h110);
      bus_write(4'h8, 32'h30);
      rd_chk("status_flags_cleared", 4'h8, 32'h0A);
      for (int i = 0; i < 8; i++) begin
         rd_chk("rx_drain", 4'h4, 32'h110 + 32'(i));
         bus_write(4'h4, 32'h0);
      end
      rd_chk("status_drained", 4'h8, 32'h06);

      // ---- RX glitch ----
      rx_glitch(16);
      rd_chk("glitch_status", 4'h8, 32'h06);
      chk("glitch_irq", {31'd0, rx_irq}, 32'd0);

      // ---- randomized RX frames vs queue model ----
      m_ovr = 1'b0; m_fe = 1'b0;
      for (int it = 0; it < 24; it++) begin
         div  = 8 + int'($urandom_range(16, 0));
         kind = int'($urandom_range(7, 0));
         b    = 8'($urandom);
         bus_write(4'hC, 32'(div));
         if (kind == 0) rx_glitch(div);
         else if (kind == 1) begin
            rx_frame(b, 1'b0, div);
            m_fe = 1'b1;
         end else begin
            rx_frame(b, 1'b1, div);
            if (mq.size() < DEPTH) mq.push_back(b);
            else m_ovr = 1'b1;
         end
         if ($urandom_range(2, 0) == 0) begin
            bus_write(4'h4, 32'($urandom));
            if (mq.size() > 0) void'(mq.pop_front());
         end
         if ($urandom_range(3, 0) == 0) begin
            logic [31:0] cw;
            cw = $urandom;
            bus_write(4'h8, cw);
            if (cw[4]) m_ovr = 1'b0;
            if (cw[5]) m_fe = 1'b0;
         end
         exp_rd = (mq.size() > 0) ? {23'd0, 1'b1, mq[0]} : 32'h0;
         exp_st = {25'd0, 1'b0, m_fe, m_ovr, (mq.size() == DEPTH), (mq.size() == 0), 1'b1, 1'b0};
         rd_chk("rand_rxdata", 4'h4, exp_rd);
         rd_chk("rand_status", 4'h8, exp_st);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
